// File: rtl/shake_squeeze.sv
// Squeeze end of the SHAKE256 datapath: unloads RATE-bit permutation blocks as MSB-first WORD-bit words.
// Optional macro SQUEEZE_MASK_TAIL_EN zeroes the bits below the valid region of the final word.
module shake_squeeze #(
    parameter int unsigned RATE  = 1088,
    parameter int unsigned WORD  = 64,
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  out_length,
    input  logic [RATE-1:0]   block_in,
    input  logic              block_valid,
    output logic              block_ready,
    output logic              perm_req,
    output logic [WORD-1:0]   data_out,
    output logic [6:0]        data_out_bits,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              data_out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NWORDS = RATE / WORD;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BITS_W = 7;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_BLK = 2'd1;
    localparam logic [1:0] EMIT     = 2'd2;
    localparam logic [1:0] REQ      = 2'd3;

    logic [1:0]        state,     state_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic [RATE-1:0]   shreg,     shreg_nxt;
    logic [IDX_W-1:0]  word_idx,  word_idx_nxt;

    logic              done_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic [BITS_W-1:0] bits_nxt;
    logic [WORD-1:0]   data_nxt;

    // Next-state plus the values every registered output takes in the next cycle
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        shreg_nxt     = shreg;
        word_idx_nxt  = word_idx;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (out_length == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        remaining_nxt = out_length;
                        state_nxt     = WAIT_BLK;
                    end
                end
            end
            WAIT_BLK: begin
                if (block_valid) begin
                    shreg_nxt    = block_in;
                    word_idx_nxt = '0;
                    state_nxt    = EMIT;
                end
            end
            EMIT: begin
                if (data_out_ready) begin
                    shreg_nxt     = shreg << WORD;
                    word_idx_nxt  = word_idx + IDX_W'(1);
                    remaining_nxt = remaining - LEN_W'(data_out_bits);
                    if (data_out_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (word_idx == IDX_W'(NWORDS - 1)) begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                state_nxt = WAIT_BLK;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        valid_nxt = (state_nxt == EMIT);
        bits_nxt  = '0;
        last_nxt  = 1'b0;
        data_nxt  = '0;
        if (valid_nxt) begin
            bits_nxt = (remaining_nxt >= LEN_W'(WORD)) ? BITS_W'(WORD) : BITS_W'(remaining_nxt);
            last_nxt = (remaining_nxt <= LEN_W'(WORD));
            data_nxt = shreg_nxt[RATE-1 -: WORD];
`ifdef SQUEEZE_MASK_TAIL_EN
            data_nxt = data_nxt & ~({WORD{1'b1}} >> bits_nxt);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            shreg          <= '0;
            word_idx       <= '0;
            block_ready    <= 1'b0;
            perm_req       <= 1'b0;
            data_out       <= '0;
            data_out_bits  <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            remaining      <= remaining_nxt;
            shreg          <= shreg_nxt;
            word_idx       <= word_idx_nxt;
            block_ready    <= (state_nxt == WAIT_BLK);
            perm_req       <= (state_nxt == REQ);
            data_out       <= data_nxt;
            data_out_bits  <= bits_nxt;
            data_out_valid <= valid_nxt;
            data_out_last  <= last_nxt;
            busy           <= (state_nxt != IDLE);
            done           <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze; expected words are derived from the supplied blocks by direct indexing.
module tb_shake_squeeze;

    localparam int unsigned RATE   = 1088;
    localparam int unsigned WORD   = 64;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned NWORDS = RATE / WORD;

    typedef struct packed {
        logic [WORD-1:0] data;
        logic [6:0]      bits;
        logic            last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] out_length;
    logic [RATE-1:0]  block_in;
    logic             block_valid;
    logic             block_ready;
    logic             perm_req;
    logic [WORD-1:0]  data_out;
    logic [6:0]       data_out_bits;
    logic             data_out_valid;
    logic             data_out_ready;
    logic             data_out_last;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [RATE-1:0] blk_q[$];
    exp_t            exp_q[$];

    shake_squeeze #(.RATE(RATE), .WORD(WORD), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .out_length(out_length),
        .block_in(block_in), .block_valid(block_valid), .block_ready(block_ready),
        .perm_req(perm_req), .data_out(data_out), .data_out_bits(data_out_bits),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WORD-1:0] got, input logic [WORD-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RATE-1:0] rand_block();
        logic [RATE-1:0] b;
        for (int k = 0; k < int'(RATE / 32); k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Expected word i comes straight from block i/NWORDS at offset i%NWORDS
    task automatic build_expect(input int len);
        int nw;
        nw = (len + WORD - 1) / WORD;
        for (int i = 0; i < nw; i++) begin
            exp_t            e;
            logic [RATE-1:0] b;
            logic [WORD-1:0] m;
            int              rem;
            b      = blk_q[i / NWORDS];
            e.data = b[RATE-1-(i % NWORDS)*WORD -: WORD];
            rem    = len - i * WORD;
            e.bits = (rem >= WORD) ? 7'(WORD) : 7'(rem);
            e.last = (i == nw - 1);
`ifdef SQUEEZE_MASK_TAIL_EN
            m      = '1;
            m      = m >> e.bits;
            e.data = e.data & ~m;
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int len, input bit noisy, input bit stall);
        int   perm_cnt, done_cnt, cyc, bi, words, stall_left, exp_perm;
        bit   acc, fin, stalled;
        logic [WORD-1:0] snap;
        exp_t e;
        perm_cnt = 0; done_cnt = 0; cyc = 0; bi = 0; words = 0; stall_left = 0;
        acc = 0; fin = 0; stalled = 0; snap = '0;
        exp_perm = (len + RATE - 1) / RATE - 1;
        build_expect(len);
        start = 1'b1; out_length = LEN_W'(len); data_out_ready = 1'b1;
        while (!fin && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (acc) check("first_word_latency", WORD'(data_out_valid), WORD'(1));
            acc = 0;
            if (perm_req) perm_cnt++;
            if (done) begin
                done_cnt++;
                fin = 1;
            end
            if (stall_left > 0 && stall_left < 5) begin
                check("stall_data", data_out, snap);
                check("stall_valid", WORD'(data_out_valid), WORD'(1));
            end
            start      = noisy ? 1'($urandom) : 1'b0;
            out_length = noisy ? LEN_W'($urandom) : LEN_W'(len);
            if (fin) begin
                start = 1'b0; block_valid = 1'b0;
            end else if (block_ready) begin
                if (bi >= blk_q.size()) begin
                    check("block_overrun", WORD'(bi), WORD'(blk_q.size() - 1));
                    block_valid = 1'b0;
                end else begin
                    block_valid = 1'b1; block_in = blk_q[bi]; bi++; acc = 1;
                end
            end else begin
                block_valid = noisy ? 1'($urandom) : 1'b0;
                block_in    = rand_block();
            end
            if (stall && !stalled && words == 3 && data_out_valid) begin
                stalled = 1; stall_left = 5; snap = data_out;
            end
            if (stall_left > 0) begin
                data_out_ready = 1'b0;
                stall_left--;
            end else begin
                data_out_ready = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (data_out_valid && data_out_ready && !fin) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", WORD'(words), WORD'((len + WORD - 1) / WORD));
                end else begin
                    e = exp_q.pop_front();
                    check("data", data_out, e.data);
                    check("bits", WORD'(data_out_bits), WORD'(e.bits));
                    check("last", WORD'(data_out_last), WORD'(e.last));
                end
                words++;
            end
        end
        if (!fin) check("timeout_done", WORD'(0), WORD'(1));
        check("perm_count", WORD'(perm_cnt), WORD'(exp_perm));
        check("done_count", WORD'(done_cnt), WORD'(1));
        check("words_left", WORD'(exp_q.size()), WORD'(0));
        block_valid = 1'b0; data_out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", WORD'(busy), WORD'(0));
        check("idle_done", WORD'(done), WORD'(0));
        exp_q.delete();
        blk_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, WORD'({block_ready, perm_req, data_out_valid, data_out_last, busy, done, data_out_bits}), WORD'(0));
        check({tag, "_data"}, data_out, WORD'(0));
    endtask

    initial begin
        int words, evts;
        logic [RATE-1:0] b;
        rst = 1'b1; start = 1'b0; out_length = '0; block_in = '0;
        block_valid = 1'b0; data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        rst = 1'b0;

        // Zero-length squeeze
        start = 1'b1; out_length = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_done", WORD'(done), WORD'(1));
        check("len0_ready", WORD'(block_ready), WORD'(0));
        check("len0_busy", WORD'(busy), WORD'(0));
        @(posedge clk); #1;
        check("len0_done_pulse", WORD'(done), WORD'(0));

        b = '0; b[RATE-1 -: 64] = 64'hA5A5_0000_FFFF_1234;
        blk_q.push_back(b);
        run(64, 0, 0);

        b = '0; b[RATE-1 -: 128] = {128{1'b1}};
        blk_q.push_back(b);
        run(100, 0, 0);

        repeat (2) blk_q.push_back(rand_block());
        run(1089, 0, 0);

        blk_q.push_back(rand_block());
        run(1088, 0, 0);

        repeat (3) blk_q.push_back(rand_block());
        run(2300, 1, 1);

        repeat (2) blk_q.push_back(rand_block());
        run(1500, 1, 0);

        // Reset during EMIT aborts without done or perm_req
        start = 1'b1; out_length = LEN_W'(500);
        words = 0; evts = 0;
        for (int c = 0; c < 50 && words < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            block_valid = block_ready;
            block_in = rand_block();
            if (data_out_valid) words++;
        end
        check("abort_reached_emit", WORD'(words), WORD'(2));
        check("abort_in_emit", WORD'(data_out_valid), WORD'(1));
        rst = 1'b1; block_valid = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("abort_outputs");
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || perm_req || busy) evts++;
        end
        check("abort_quiet", WORD'(evts), WORD'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
